hil_bridge_voltage_src: RTL and testbench
=========================================

// Module: hil_bridge_voltage_src
// PURPOSE
//  Upstream source for the HIL RL plant: converts raw H-bridge gate signals from the controller
//  under test into the averaged bridge voltage driven onto the plant's sig1 input.
//  Averages over one model step of WINDOW clocks; signed Q24.8 output, held between updates.
//  Detects shoot-through (both gates high) and forces a safe zero-voltage FAULT state.
// PARAMETERS
//  WINDOW     10      clocks per averaging window; equals plant step length (1..32767)
//  RECIP      104858  round(2^20/WINDOW), Q0.20 reciprocal used for the divide
//  SHOOT_MAX  1       consecutive synced clocks with both gates high that trigger FAULT
//  SYNC_STG   2       synchronizer flops on gate_hi/gate_lo (>=2)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous, active-low reset
//  en         in   1   enable; low = IDLE
//  udc        in   32  signed Q24.8 DC-link voltage
//  gate_hi    in   1   raw high-side gate from the controller under test (async)
//  gate_lo    in   1   raw low-side gate (async)
//  fault_clr  in   1   clears sticky fault (level, sampled each clock)
//  u_out      out  32  signed Q24.8 averaged bridge voltage -> plant sig1
//  u_valid    out  1   one-clock pulse when u_out updates
//  fault      out  1   sticky shoot-through flag
//  win_cnt    out  16  current window position (diagnostic)
// BEHAVIOUR
//  Reset (rst=0, async): u_out=0, u_valid=0, fault=0, win_cnt=0, n_hi=n_lo=0, sync flops=0, state IDLE.
//  Sync: gate_hi/gate_lo pass SYNC_STG flops; all logic uses synced hs/ls only.
//  Per clock in RUN: hs&!ls -> n_hi++; ls&!hs -> n_lo++; neither (deadtime) -> no count;
//   hs&ls -> no count, shoot counter++ (cleared on any clock without hs&ls).
//  FSM states IDLE, RUN, FAULT:
//   IDLE: en=0; counters held 0, u_out=0, no u_valid. en=1 -> RUN at win_cnt=0.
//   RUN: win_cnt 0..WINDOW-1, wraps to 0. At win_cnt=0 latch udc into udc_q (no mid-window change).
//    At win_cnt=WINDOW-1 freeze diff=n_hi-n_lo (17b signed, includes that clock's count), clear n_hi/n_lo.
//    shoot counter reaches SHOOT_MAX -> FAULT next clock, fault=1, window aborted, no u_valid for it.
//    en=0 in any state -> IDLE next clock (aborts window and any pending pipeline result).
//   FAULT: u_out forced 0 next clock; window counter keeps running, u_valid pulses each window with u_out=0.
//    fault_clr=1 and hs&ls=0 -> RUN at win_cnt=0, fault=0; fault_clr while hs&ls=1 ignored.
//  Arithmetic (2-stage pipeline after window end):
//   S1: p1 = udc_q * diff (49b signed); S2: p2 = p1 * RECIP (67b signed), y = p2 >>> 20 (arith).
//   y clamped to [-2^31, 2^31-1]; u_out <= y and u_valid=1 two clocks after win_cnt=WINDOW-1.
//  u_out holds its value between pulses (plant samples every clock).
//  Back-to-back windows: no gap; pipeline accepts a new diff every WINDOW clocks (WINDOW>=3 required).
// TESTING
//  T1 udc=51200 (200V), gate_hi=1 all window, WINDOW=10 -> u_out=51200, u_valid 2 clk after win end.
//  T2 hi 7 clk, lo 3 clk per window -> diff=4, u_out=20480 (80V); hi 3/lo 7 -> u_out=-20480.
//  T3 hi 4, deadtime 2, lo 4 -> u_out=0; hi 5, deadtime 5 -> u_out=25600.
//  T4 both gates high 1 synced clk mid-window -> fault=1, u_out=0, later pulses u_out=0;
//     fault_clr with gates legal -> fault=0, restart at win_cnt=0, next window correct value.
//  T5 udc changed mid-window 51200->25600 -> current window uses 51200; next window uses 25600.
//  T6 rst low mid-window and en low mid-window -> all outputs 0 immediately (rst) or next clk (en), no stale u_valid.

Source files
------------

// File: rtl/hil_bridge_voltage_src.sv
// hil_bridge_voltage_src: averages synchronized H-bridge gate states over one plant step
// into a signed Q24.8 bridge voltage, with a sticky shoot-through fault that forces 0 V.
module hil_bridge_voltage_src #(
    parameter int WINDOW    = 10,
    parameter int RECIP     = 104858,
    parameter int SHOOT_MAX = 1,
    parameter int SYNC_STG  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [31:0] udc,
    input  logic        gate_hi,
    input  logic        gate_lo,
    input  logic        fault_clr,
    output logic [31:0] u_out,
    output logic        u_valid,
    output logic        fault,
    output logic [15:0] win_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
    localparam logic signed [22:0] RCP  = 23'(RECIP);
    localparam logic signed [71:0] YMAX = 72'sd2147483647;
    localparam logic signed [71:0] YMIN = -72'sd2147483648;
    state_t state, state_nxt;
    logic [SYNC_STG-1:0] sh, sl;
    logic hs, ls, both, trans, win_end, v1;
    logic [15:0] n_hi, n_lo, hi_n, lo_n, shoot, shoot_n;
    logic signed [31:0] udc_q;
    logic signed [16:0] diff;
    logic signed [48:0] p1;
    logic signed [71:0] y;
    logic [31:0] sat;
    always_comb begin
        hs        = sh[SYNC_STG-1];
        ls        = sl[SYNC_STG-1];
        both      = hs & ls;
        shoot_n   = both ? shoot + 16'd1 : 16'd0;
        state_nxt = !en ? IDLE : state == IDLE ? RUN :
                    state == RUN ? (shoot_n >= 16'(SHOOT_MAX) ? FAULT : RUN) :
                    (fault_clr && !both ? RUN : FAULT);
        trans     = state_nxt != state;
        win_end   = state != IDLE && win_cnt == 16'(WINDOW - 1);
        hi_n      = n_hi + {15'd0, hs & !ls};
        lo_n      = n_lo + {15'd0, ls & !hs};
        // a FAULT window feeds a zero difference so its pulse carries 0 V
        diff      = state == RUN ? 17'(hi_n) - 17'(lo_n) : 17'sd0;
        y         = (72'(p1) * 72'(RCP)) >>> 20;
        sat       = y > YMAX ? 32'h7fff_ffff : y < YMIN ? 32'h8000_0000 : y[31:0];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh      <= '0;
            sl      <= '0;
            state   <= IDLE;
            fault   <= 1'b0;
            shoot   <= '0;
            win_cnt <= '0;
            n_hi    <= '0;
            n_lo    <= '0;
            udc_q   <= '0;
            p1      <= '0;
            v1      <= 1'b0;
            u_valid <= 1'b0;
            u_out   <= '0;
        end else begin
            sh      <= {sh[SYNC_STG-2:0], gate_hi};
            sl      <= {sl[SYNC_STG-2:0], gate_lo};
            state   <= state_nxt;
            fault   <= state_nxt == FAULT;
            shoot   <= state == RUN && state_nxt == RUN ? shoot_n : 16'd0;
            win_cnt <= state_nxt == IDLE || (trans && state_nxt == RUN) || win_end ? 16'd0 : win_cnt + 16'd1;
            n_hi    <= state_nxt != RUN || trans || win_end ? 16'd0 : hi_n;
            n_lo    <= state_nxt != RUN || trans || win_end ? 16'd0 : lo_n;
            if (state == RUN && win_cnt == 16'd0) udc_q <= udc;
            // any state change discards results still in flight
            v1      <= win_end && !trans;
            p1      <= 49'(udc_q) * 49'(diff);
            u_valid <= v1 && !trans;
            u_out   <= state_nxt != RUN ? 32'd0 : v1 && !trans ? sat : u_out;
        end
    end
endmodule

// File: tb/tb_hil_bridge_voltage_src.sv
// tb_hil_bridge_voltage_src: randomized and directed stimulus against a window-level
// reference model; a monitor checks every u_valid pulse and the per-clock outputs.
module tb_hil_bridge_voltage_src;
    localparam int W = 10, RECIP = 104858, SMAX = 1, SS = 2;
    logic clk = 0, rst = 0, en = 0, gate_hi = 0, gate_lo = 0, fault_clr = 0;
    logic [31:0] udc = 0;
    logic [31:0] u_out;
    logic u_valid, fault;
    logic [15:0] win_cnt;
    always #5 clk = ~clk;
    hil_bridge_voltage_src #(.WINDOW(W), .RECIP(RECIP), .SHOOT_MAX(SMAX), .SYNC_STG(SS)) dut (
        .clk(clk), .rst(rst), .en(en), .udc(udc), .gate_hi(gate_hi), .gate_lo(gate_lo),
        .fault_clr(fault_clr), .u_out(u_out), .u_valid(u_valid), .fault(fault), .win_cnt(win_cnt));
    typedef struct {int k; logic [31:0] v;} ent_t;
    ent_t sb[$], pend[$];
    logic [31:0] eu[int];
    logic ef[int];
    logic [15:0] ew[int];
    int cyc = 0, vectors = 0, miscompares = 0;
    int mode, wc, nhi, nlo, shoot;
    logic [31:0] udcq, m_u;
    logic m_f;
    logic hq[$], lq[$];
    always @(posedge clk) cyc++;
    function automatic logic [31:0] avg(logic [31:0] ud, int d);
        longint p;
        p = (longint'($signed(ud)) * longint'(d) * longint'(RECIP)) >>> 20;
        return p > 64'sd2147483647 ? 32'h7fff_ffff : p < -64'sd2147483648 ? 32'h8000_0000 : p[31:0];
    endfunction
    task automatic chk(string n, logic [63:0] a, logic [63:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask
    task automatic do_reset();
        rst = 0; en = 0; gate_hi = 0; gate_lo = 0; fault_clr = 0;
        sb.delete(); pend.delete(); eu.delete(); ef.delete(); ew.delete();
        hq.delete(); lq.delete();
        repeat (SS) begin hq.push_back(0); lq.push_back(0); end
        mode = 0; wc = 0; nhi = 0; nlo = 0; shoot = 0; udcq = 0; m_u = 0; m_f = 0;
        repeat (3) @(negedge clk);
        rst = 1;
    endtask
    // one clock of stimulus; the model predicts the state right after the coming edge
    task automatic step(logic e, logic c, logic h, logic l, logic [31:0] u);
        int k, nm, sn;
        logic hs, ls, both;
        ent_t t;
        k = cyc + 1;
        en = e; fault_clr = c; gate_hi = h; gate_lo = l; udc = u;
        hs = hq.pop_front(); ls = lq.pop_front();
        hq.push_back(h); lq.push_back(l);
        both = hs && ls;
        sn = both ? shoot + 1 : 0;
        nm = !e ? 0 : mode == 0 ? 1 : mode == 1 ? (sn >= SMAX ? 2 : 1) : (c && !both ? 1 : 2);
        if (nm != mode) pend.delete();
        else if (pend.size() > 0 && pend[0].k == k) begin
            t = pend.pop_front();
            sb.push_back(t);
            m_u = t.v;
        end
        if (nm != 1) m_u = 0;
        if (mode == 1) begin
            if (hs && !ls) nhi++;
            if (ls && !hs) nlo++;
            if (wc == 0) udcq = u;
        end
        if (mode != 0 && wc == W - 1 && nm == mode)
            pend.push_back('{k + 1, mode == 1 ? avg(udcq, nhi - nlo) : 32'd0});
        if (wc == W - 1 || nm != 1 || nm != mode) begin nhi = 0; nlo = 0; end
        wc = (nm == 0 || (nm != mode && nm == 1) || wc == W - 1) ? 0 : wc + 1;
        shoot = (mode == 1 && nm == 1) ? sn : 0;
        mode = nm;
        m_f = nm == 2;
        eu[k] = m_u; ef[k] = m_f; ew[k] = 16'(wc);
        @(negedge clk);
    endtask
    task automatic win(int nh, int nd, logic [31:0] u, int reps);
        for (int r = 0; r < reps; r++)
            for (int i = 0; i < W; i++) step(1, 0, i < nh, i >= nh + nd, u);
    endtask
    always @(posedge clk) begin
        #1;
        if (rst) begin
            while (sb.size() > 0 && sb[0].k < cyc) begin
                vectors++; miscompares++;
                $display("FAIL missing_pulse: got none at cycle %0d expected u_out %0h", sb[0].k, sb[0].v);
                void'(sb.pop_front());
            end
            if (u_valid) begin
                if (sb.size() == 0 || sb[0].k != cyc) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_pulse: got u_valid at cycle %0d expected none", cyc);
                end else chk("pulse_u_out", u_out, sb.pop_front().v);
            end
            if (eu.exists(cyc))
                chk("u_out/fault/win_cnt", {u_out, 15'd0, fault, win_cnt}, {eu[cyc], 15'd0, ef[cyc], ew[cyc]});
        end
    end
    initial begin
        @(negedge clk);
        do_reset();
        chk("reset_u_out", u_out, 0);
        chk("reset_u_valid", u_valid, 0);
        chk("reset_fault", fault, 0);
        chk("reset_win_cnt", win_cnt, 0);
        win(10, 0, 51200, 3);
        win(7, 0, 51200, 3);
        win(3, 0, 51200, 3);
        win(4, 2, 51200, 3);
        win(5, 5, 51200, 3);
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < W; i++) step(1, 0, i < 6, i >= 6, (r == 0 && i < 5) ? 51200 : 25600);
        win(10, 0, 32'h7fff_ffff, 2);
        win(0, 0, 32'h8000_0000, 2);
        repeat (4) step(1, 0, 1, 0, 51200);
        step(1, 0, 1, 1, 51200);
        repeat (35) step(1, 0, 0, 1, 51200);
        step(1, 0, 1, 1, 51200);
        step(1, 0, 1, 1, 51200);
        step(1, 1, 1, 1, 51200);
        step(1, 1, 0, 0, 51200);
        repeat (5) step(1, 0, 0, 0, 51200);
        step(1, 1, 0, 1, 51200);
        win(7, 0, 51200, 3);
        repeat (4) step(1, 0, 1, 0, 25600);
        step(0, 0, 1, 0, 25600);
        win(8, 1, 25600, 2);
        repeat (400) begin
            int g;
            g = $urandom_range(0, 39);
            step($urandom_range(0, 49) != 0, $urandom_range(0, 7) == 0,
                 g == 0 || g < 14, g == 0 || (g >= 14 && g < 27), $urandom);
        end
        win(10, 0, 51200, 2);
        for (int i = 0; i < 2 * W && pend.size() == 0; i++) step(1, 0, 1, 0, 51200);
        #2 rst = 0;
        #1;
        chk("async_rst_u_out", u_out, 0);
        chk("async_rst_u_valid", u_valid, 0);
        chk("async_rst_fault", fault, 0);
        chk("async_rst_win_cnt", win_cnt, 0);
        @(negedge clk);
        do_reset();
        win(2, 0, 76800, 3);
        repeat (4) step(1, 0, 0, 0, 0);
        chk("drain_pending", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
